// File: rtl/tictactoe_video_pkg.sv
// -----------------------------------------------------------------------------
// tictactoe_video_pkg
// Shared definitions for the serial data packer:
//   - default word width, symbol width, frame length and address width
//   - encoding of the holding-register state (S_EMPTY / S_FULL)
//   - width helper for the symbol counter
// No ports (package).
// -----------------------------------------------------------------------------
package tictactoe_video_pkg;

  localparam int DEFAULT_ROM_DATA_WIDTH  = 96;
  localparam int DEFAULT_SELECT_SIZE     = 3;
  localparam int DEFAULT_WORDS_PER_FRAME = 600;
  localparam int DEFAULT_ADDR_WIDTH      = 10;

  // Holding register occupancy
  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } hold_state_e;

  // Counter width able to index n symbols; never narrower than one bit
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/serial_data_packer_symbol_assembler.sv
// -----------------------------------------------------------------------------
// symbol_assembler
// Collects SELECT_SIZE-bit symbols into a ROM_DATA_WIDTH-bit word, first
// symbol in the least significant position.
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   clear_i      restart the word; a symbol accepted this cycle becomes symbol 0
//   data_i       incoming symbol
//   valid_i      symbol qualifier
//   word_done_o  combinational: this cycle's symbol completes a word
//   word_o       combinational: the completed word (valid with word_done_o)
// -----------------------------------------------------------------------------
module symbol_assembler
  import tictactoe_video_pkg::*;
#(
  parameter int ROM_DATA_WIDTH = DEFAULT_ROM_DATA_WIDTH,
  parameter int SELECT_SIZE    = DEFAULT_SELECT_SIZE
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic [SELECT_SIZE-1:0]    data_i,
  input  logic                      valid_i,
  output logic                      word_done_o,
  output logic [ROM_DATA_WIDTH-1:0] word_o
);

  localparam int N     = ROM_DATA_WIDTH / SELECT_SIZE;
  localparam int CNT_W = cnt_width(N);

  logic [CNT_W-1:0]                    cnt_q;
  logic [CNT_W-1:0]                    cnt_d;
  logic [CNT_W-1:0]                    cnt_base_s;
  logic [ROM_DATA_WIDTH-1:0]           sr_q;
  logic [ROM_DATA_WIDTH-1:0]           sr_d;
  logic [ROM_DATA_WIDTH+SELECT_SIZE-1:0] cat_s;
  logic [ROM_DATA_WIDTH-1:0]           shifted_s;

  // Shift/count next-state: new symbols enter at the top and move down, so
  // after N symbols the first one sits in the lowest slot. Stale bits left
  // over from a cleared partial word are shifted out before completion.
  always_comb begin
    if (clear_i) begin
      cnt_base_s = '0;
    end else begin
      cnt_base_s = cnt_q;
    end

    cat_s       = {data_i, sr_q};
    shifted_s   = cat_s[ROM_DATA_WIDTH+SELECT_SIZE-1:SELECT_SIZE];
    word_done_o = valid_i && (cnt_base_s == CNT_W'(N - 1));
    word_o      = shifted_s;

    if (valid_i) begin
      sr_d = shifted_s;
      if (word_done_o) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_base_s + CNT_W'(1);
      end
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_base_s;
    end
  end

  // Assembly state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/serial_data_packer.sv
// -----------------------------------------------------------------------------
// serial_data_packer
// Packs a stream of SELECT_SIZE-bit symbols into ROM_DATA_WIDTH-bit words and
// presents each completed word with its frame address through a single-entry
// holding register and a valid/ready style write handshake.
// Ports:
//   clk_i           rising-edge clock
//   rst_i           synchronous active-high reset (highest priority)
//   serial_data_i   incoming symbol
//   serial_valid_i  symbol qualifier
//   frame_start_i   restarts the frame: partial word dropped, address -> 0
//   word_ready_i    memory accepts the presented word this cycle
//   word_we_o       write request (holding register full)
//   word_data_o     packed word, stable while word_we_o is high
//   word_addr_o     word address, stable while word_we_o is high
//   overflow_o      sticky: a completed word was discarded
//   frame_done_o    (only with SERIAL_PACKER_FRAME_DONE_EN) one-cycle pulse
//                   after the last address of the frame is transferred
// Build option: define SERIAL_PACKER_FRAME_DONE_EN to add frame_done_o.
// -----------------------------------------------------------------------------
module serial_data_packer
  import tictactoe_video_pkg::*;
#(
  parameter int ROM_DATA_WIDTH  = DEFAULT_ROM_DATA_WIDTH,
  parameter int SELECT_SIZE     = DEFAULT_SELECT_SIZE,
  parameter int WORDS_PER_FRAME = DEFAULT_WORDS_PER_FRAME,
  parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [SELECT_SIZE-1:0]    serial_data_i,
  input  logic                      serial_valid_i,
  input  logic                      frame_start_i,
  input  logic                      word_ready_i,
  output logic                      word_we_o,
  output logic [ROM_DATA_WIDTH-1:0] word_data_o,
  output logic [ADDR_WIDTH-1:0]     word_addr_o,
  output logic                      overflow_o
`ifdef SERIAL_PACKER_FRAME_DONE_EN
  ,
  output logic                      frame_done_o
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS_PER_FRAME - 1);

  hold_state_e               state_q;
  hold_state_e               state_d;
  logic [ROM_DATA_WIDTH-1:0] data_q;
  logic [ROM_DATA_WIDTH-1:0] data_d;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [ADDR_WIDTH-1:0]     addr_d;
  logic [ADDR_WIDTH-1:0]     next_addr_q;
  logic [ADDR_WIDTH-1:0]     next_addr_d;
  logic                      overflow_q;
  logic                      overflow_d;

  logic                      word_done_s;
  logic [ROM_DATA_WIDTH-1:0] assembled_s;
  logic                      transfer_s;
  logic                      load_s;
  logic [ADDR_WIDTH-1:0]     addr_base_s;

  // Frame-relative address successor, wrapping at the end of the frame
  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    if (a == LAST_ADDR) begin
      return '0;
    end else begin
      return a + ADDR_WIDTH'(1);
    end
  endfunction

  symbol_assembler #(
    .ROM_DATA_WIDTH (ROM_DATA_WIDTH),
    .SELECT_SIZE    (SELECT_SIZE)
  ) u_assembler (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (frame_start_i),
    .data_i      (serial_data_i),
    .valid_i     (serial_valid_i),
    .word_done_o (word_done_s),
    .word_o      (assembled_s)
  );

  // Holding register / handshake next-state. A word completing while the
  // held word leaves this same cycle replaces it without a bubble; a word
  // completing while the held word is stuck is dropped and flagged.
  always_comb begin
    transfer_s = (state_q == S_FULL) && word_ready_i;

    if (frame_start_i) begin
      addr_base_s = '0;
    end else begin
      addr_base_s = next_addr_q;
    end

    case (state_q)
      S_EMPTY: load_s = word_done_s;
      S_FULL:  load_s = word_done_s && word_ready_i;
      default: load_s = 1'b0;
    endcase

    state_d     = state_q;
    data_d      = data_q;
    addr_d      = addr_q;
    next_addr_d = addr_base_s;

    if (load_s) begin
      state_d     = S_FULL;
      data_d      = assembled_s;
      addr_d      = addr_base_s;
      next_addr_d = addr_inc(addr_base_s);
    end else if (transfer_s) begin
      state_d     = S_EMPTY;
    end else begin
      state_d     = state_q;
    end

    if (word_done_s && !load_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Holding register, address and status flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_EMPTY;
      data_q      <= '0;
      addr_q      <= '0;
      next_addr_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      overflow_q  <= overflow_d;
    end
  end

  assign word_we_o   = (state_q == S_FULL);
  assign word_data_o = data_q;
  assign word_addr_o = addr_q;
  assign overflow_o  = overflow_q;

`ifdef SERIAL_PACKER_FRAME_DONE_EN
  logic frame_done_q;
  logic frame_done_d;

  // Flag the transfer of the final address of the frame
  always_comb begin
    if (transfer_s && (addr_q == LAST_ADDR)) begin
      frame_done_d = 1'b1;
    end else begin
      frame_done_d = 1'b0;
    end
  end

  // Frame-done pulse register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done_o = frame_done_q;
`endif

endmodule

// File: tb/tb_serial_data_packer.sv
// -----------------------------------------------------------------------------
// tb_serial_data_packer
// Self-checking bench for serial_data_packer (WORDS_PER_FRAME=4 so that
// address wrap happens quickly). A queue-based reference model tracks the
// symbol stream, the held word, addresses and the overflow flag.
// -----------------------------------------------------------------------------
module tb_serial_data_packer;

  localparam int RW  = 96;
  localparam int SS  = 3;
  localparam int NS  = RW / SS;
  localparam int WPF = 4;
  localparam int AW  = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [SS-1:0] sdata;
  logic          svalid;
  logic          fstart;
  logic          ready;
  logic          we;
  logic [RW-1:0] data;
  logic [AW-1:0] addr;
  logic          ovf;
`ifdef SERIAL_PACKER_FRAME_DONE_EN
  logic          fdone;
`endif

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit            m_full;
  logic [RW-1:0] m_data;
  int            m_addr;
  int            m_next;
  bit            m_ovf;
  bit            m_fd;
  int            syms[$];

  always #5 clk = ~clk;

  serial_data_packer #(
    .ROM_DATA_WIDTH  (RW),
    .SELECT_SIZE     (SS),
    .WORDS_PER_FRAME (WPF),
    .ADDR_WIDTH      (AW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .serial_data_i  (sdata),
    .serial_valid_i (svalid),
    .frame_start_i  (fstart),
    .word_ready_i   (ready),
    .word_we_o      (we),
    .word_data_o    (data),
    .word_addr_o    (addr),
    .overflow_o     (ovf)
`ifdef SERIAL_PACKER_FRAME_DONE_EN
    ,
    .frame_done_o   (fdone)
`endif
  );

  function automatic logic [RW-1:0] pack(input int q[$]);
    logic [RW-1:0] w;
    w = '0;
    for (int k = 0; k < q.size(); k++) begin
      w = w | (RW'(q[k]) << (k * SS));
    end
    return w;
  endfunction

  task automatic model_step();
    bit            xfer;
    bit            done;
    logic [RW-1:0] w;
    w = '0;
    if (rst) begin
      m_full = 0; m_data = '0; m_addr = 0; m_next = 0; m_ovf = 0; m_fd = 0;
      syms.delete();
    end else begin
      xfer = m_full && ready;
      m_fd = xfer && (m_addr == WPF - 1);
      if (fstart) begin
        syms.delete();
        m_next = 0;
      end
      done = 0;
      if (svalid) begin
        syms.push_back(int'(sdata));
        if (syms.size() == NS) begin
          w = pack(syms);
          syms.delete();
          done = 1;
        end
      end
      if (xfer) m_full = 0;
      if (done) begin
        if (!m_full) begin
          m_full = 1; m_data = w; m_addr = m_next; m_next = (m_next + 1) % WPF;
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send_sym(input int s);
    sdata  = SS'(s);
    svalid = 1'b1;
    tick();
    svalid = 1'b0;
    sdata  = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; svalid = 1'b0; fstart = 1'b0; ready = 1'b0; sdata = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (we !== 1'b0 || data !== '0 || addr !== '0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: we=%b data=%h addr=%0d ovf=%b, required all zero", we, data, addr, ovf);
    end
  endtask

  task automatic test_first_word();
    logic [RW-1:0] d;
    reset_dut();
    ready = 1'b1;
    for (int k = 0; k < NS - 1; k++) send_sym(k % 8);
    checks++;
    if (we !== 1'b0) begin
      failures++;
      $display("FAIL first_word_early_we: we=%b before last symbol, required 0", we);
    end
    send_sym((NS - 1) % 8);
    d = data;
    checks++;
    if (we !== 1'b1 || addr !== '0) begin
      failures++;
      $display("FAIL first_word_we_addr: we=%b addr=%0d, required we=1 addr=0", we, addr);
    end
    checks++;
    if (d[2:0] !== 3'd0 || d[5:3] !== 3'd1 || d[95:93] !== 3'd7) begin
      failures++;
      $display("FAIL first_word_bits: [2:0]=%0d [5:3]=%0d [95:93]=%0d, required 0,1,7", d[2:0], d[5:3], d[95:93]);
    end
    checks++;
    if (d !== m_data) begin
      failures++;
      $display("FAIL first_word_data: got %h expected %h", d, m_data);
    end
    tick();
    checks++;
    if (we !== 1'b0) begin
      failures++;
      $display("FAIL first_word_one_cycle: we=%b, required 0", we);
    end
  endtask

  task automatic test_backpressure();
    int            q[$];
    logic [RW-1:0] exp;
    reset_dut();
    ready = 1'b0;
    for (int k = 0; k < NS; k++) begin
      q.push_back(int'($urandom_range(0, 7)));
      send_sym(q[k]);
    end
    exp = pack(q);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (we !== 1'b1 || data !== exp || addr !== '0) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: we=%b data=%h addr=%0d, required we=1 data=%h addr=0", c, we, data, addr, exp);
      end
      tick();
    end
    ready = 1'b1;
    tick();
    checks++;
    if (we !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release: we=%b, required 0", we);
    end
    for (int k = 0; k < NS; k++) send_sym(int'($urandom_range(0, 7)));
    checks++;
    if (we !== 1'b1 || addr !== AW'(1)) begin
      failures++;
      $display("FAIL backpressure_next_addr: we=%b addr=%0d, required we=1 addr=1", we, addr);
    end
    tick();
  endtask

  task automatic test_overflow();
    int            q[$];
    logic [RW-1:0] exp;
    reset_dut();
    ready = 1'b0;
    for (int k = 0; k < 2 * NS; k++) begin
      q.push_back(int'($urandom_range(0, 7)));
      send_sym(q[k]);
    end
    q = q[0:NS-1];
    exp = pack(q);
    checks++;
    if (we !== 1'b1 || data !== exp || addr !== '0 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL overflow_keep_first: we=%b data=%h addr=%0d ovf=%b, required 1 %h 0 1", we, data, addr, ovf, exp);
    end
    for (int c = 0; c < 3; c++) tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (we !== 1'b0 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky: we=%b ovf=%b, required we=0 ovf=1", we, ovf);
    end
    reset_dut();
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL overflow_reset: ovf=%b, required 0", ovf);
    end
  endtask

  task automatic test_wrap();
    int seen[$];
    int fd_cycles[$];
    int addr3_cycle;
    addr3_cycle = -1;
    reset_dut();
    ready = 1'b1;
    for (int c = 0; c < 5 * NS + 2; c++) begin
      if (c < 5 * NS) begin
        svalid = 1'b1;
        sdata  = SS'($urandom_range(0, 7));
      end else begin
        svalid = 1'b0;
      end
      tick();
      if (we) seen.push_back(int'(addr));
      if (we && addr == AW'(WPF - 1)) addr3_cycle = c;
`ifdef SERIAL_PACKER_FRAME_DONE_EN
      if (fdone) fd_cycles.push_back(c);
`endif
    end
    svalid = 1'b0;
    checks++;
    if (seen.size() != 5) begin
      failures++;
      $display("FAIL wrap_count: %0d words presented, required 5", seen.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (seen[i] != (i % WPF)) begin
          failures++;
          $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, seen[i], i % WPF);
        end
      end
    end
`ifdef SERIAL_PACKER_FRAME_DONE_EN
    checks++;
    if (fd_cycles.size() != 1 || fd_cycles[0] != addr3_cycle + 1) begin
      failures++;
      $display("FAIL frame_done_pulse: %0d pulses (first at %0d), required 1 at cycle %0d",
               fd_cycles.size(), (fd_cycles.size() > 0) ? fd_cycles[0] : -1, addr3_cycle + 1);
    end
`endif
  endtask

  task automatic test_frame_start();
    int q[$];
    int x;
    reset_dut();
    ready = 1'b1;
    for (int k = 0; k < NS; k++) send_sym(int'($urandom_range(0, 7)));
    for (int k = 0; k < 10; k++) send_sym(int'($urandom_range(0, 7)));
    fstart = 1'b1;
    tick();
    fstart = 1'b0;
    for (int k = 0; k < NS; k++) begin
      q.push_back(int'($urandom_range(0, 7)));
      send_sym(q[k]);
    end
    checks++;
    if (we !== 1'b1 || addr !== '0 || data !== pack(q)) begin
      failures++;
      $display("FAIL frame_start_restart: we=%b addr=%0d data=%h, required 1 0 %h", we, addr, data, pack(q));
    end
    tick();
    for (int k = 0; k < 5; k++) send_sym(int'($urandom_range(0, 7)));
    q.delete();
    x = int'($urandom_range(0, 7));
    q.push_back(x);
    fstart = 1'b1;
    send_sym(x);
    fstart = 1'b0;
    for (int k = 1; k < NS; k++) begin
      q.push_back(int'($urandom_range(0, 7)));
      send_sym(q[k]);
    end
    checks++;
    if (we !== 1'b1 || addr !== '0 || data !== pack(q)) begin
      failures++;
      $display("FAIL frame_start_coincident: we=%b addr=%0d data=%h, required 1 0 %h", we, addr, data, pack(q));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    ready = 1'b0;
    for (int k = 0; k < NS; k++) send_sym(int'($urandom_range(1, 7)));
    checks++;
    if (we !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_precond: we=%b, required 1", we);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (we !== 1'b0 || data !== '0 || addr !== '0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_clear: we=%b data=%h addr=%0d ovf=%b, required all zero", we, data, addr, ovf);
    end
    ready = 1'b1;
    for (int k = 0; k < NS; k++) send_sym(int'($urandom_range(0, 7)));
    checks++;
    if (we !== 1'b1 || addr !== '0) begin
      failures++;
      $display("FAIL reset_mid_next: we=%b addr=%0d, required we=1 addr=0", we, addr);
    end
    tick();
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      svalid = ($urandom % 10) < 7;
      sdata  = SS'($urandom_range(0, 7));
      ready  = ($urandom % 2) == 0;
      fstart = ($urandom % 50) == 0;
      rst    = ($urandom % 500) == 0;
      tick();
      checks++;
      if (we !== m_full || data !== m_data || addr !== AW'(m_addr) || ovf !== m_ovf) begin
        failures++;
        $display("FAIL random[%0d]: we=%b addr=%0d ovf=%b data=%h, required we=%b addr=%0d ovf=%b data=%h",
                 c, we, addr, ovf, data, m_full, m_addr, m_ovf, m_data);
      end
`ifdef SERIAL_PACKER_FRAME_DONE_EN
      checks++;
      if (fdone !== m_fd) begin
        failures++;
        $display("FAIL random_frame_done[%0d]: got %b expected %b", c, fdone, m_fd);
      end
`endif
    end
    svalid = 1'b0; ready = 1'b0; fstart = 1'b0; rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; sdata = '0; svalid = 1'b0; fstart = 1'b0; ready = 1'b0;
    test_reset();
    test_first_word();
    test_backpressure();
    test_overflow();
    test_wrap();
    test_frame_start();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_data_packer.md
SERIAL_DATA_PACKER -- requirements
Module: serial_data_packer

Interface
REQ-001 SHALL have parameter ROM_DATA_WIDTH, default 96, packed word width in bits.
REQ-002 SHALL have parameter SELECT_SIZE, default 3, symbol width in bits; ROM_DATA_WIDTH divisible by SELECT_SIZE.
REQ-003 SHALL have parameter WORDS_PER_FRAME, default 600, number of words per frame; address wraps after the last word.
REQ-004 SHALL have parameter ADDR_WIDTH, default 10, word address width; 2**ADDR_WIDTH >= WORDS_PER_FRAME.
REQ-005 clk_i  input  1  single clock; all logic on rising edge.
REQ-006 rst_i  input  1  synchronous, active-high reset.
REQ-007 serial_data_i  input  SELECT_SIZE  incoming symbol.
REQ-008 serial_valid_i  input  1  symbol qualifier; one symbol accepted per cycle when high.
REQ-009 frame_start_i  input  1  single-cycle frame restart strobe.
REQ-010 word_ready_i  input  1  memory accepts the word this cycle.
REQ-011 word_we_o  output  1  write request; a transfer occurs on any cycle with word_we_o and word_ready_i both high.
REQ-012 word_data_o  output  ROM_DATA_WIDTH  packed word; stable while word_we_o is high.
REQ-013 word_addr_o  output  ADDR_WIDTH  word address; stable while word_we_o is high.
REQ-014 overflow_o  output  1  sticky flag: a completed word was lost.

Function
REQ-015 SHALL pack N = ROM_DATA_WIDTH/SELECT_SIZE symbols per word, LSB first: symbol k of a word occupies bits [(k+1)*SELECT_SIZE-1 : k*SELECT_SIZE].
REQ-016 SHALL hold an assembly register and a holding register; holding-register state machine has states S_EMPTY and S_FULL.
REQ-017 On acceptance of symbol N-1 with holding register in S_EMPTY (or S_FULL and transferring that same cycle), the word SHALL move to the holding register; state becomes S_FULL.
REQ-018 word_we_o SHALL be high exactly when state is S_FULL; it rises the cycle after the last symbol is accepted (latency 1).
REQ-019 A transfer SHALL return state to S_EMPTY unless a new word loads the same cycle (REQ-017), in which case it stays S_FULL.
REQ-020 On completion of a word while S_FULL and no transfer, SHALL discard the new word, keep the held word, and set overflow_o.
REQ-021 Word address SHALL be assigned at load into the holding register, starting at 0, incrementing by 1 per loaded word, wrapping from WORDS_PER_FRAME-1 to 0.
REQ-022 frame_start_i SHALL clear the assembly symbol count and next-address to 0; a word already in the holding register SHALL complete with its original address.
REQ-023 frame_start_i coincident with serial_valid_i SHALL make that symbol symbol 0 of a new word at address 0.
REQ-024 Symbol counter SHALL not advance on cycles with serial_valid_i low; partial words persist indefinitely.

Reset
REQ-025 rst_i SHALL set word_we_o=0, word_data_o=0, word_addr_o=0, overflow_o=0, symbol count 0, next-address 0, state S_EMPTY.
REQ-026 rst_i SHALL take priority over all inputs, including mid-word and mid-handshake; the pending word is dropped.

Configuration
REQ-027 With SERIAL_PACKER_FRAME_DONE_EN defined, SHALL add output frame_done_o (1 bit, reset 0) pulsing high one cycle after the transfer of address WORDS_PER_FRAME-1.
REQ-028 Without SERIAL_PACKER_FRAME_DONE_EN, the port and its logic SHALL not exist.

Structure
REQ-029 Shared package tictactoe_video_pkg SHALL hold default ROM_DATA_WIDTH, SELECT_SIZE, WORDS_PER_FRAME and the S_EMPTY/S_FULL encoding.
REQ-030 Symbol assembly (shift register plus counter) SHALL be a sub-module symbol_assembler; holding/handshake logic stays in the top.

Verification
REQ-031 Reset, then 32 valid symbols 0..7 repeating, word_ready_i=1 -> one-cycle word_we_o, addr 0, word bits [2:0]=0, [5:3]=1, [95:93]=7.
REQ-032 Complete word with word_ready_i=0 for 5 cycles -> word_we_o held high, data/addr stable, transfer on cycle ready rises, addr next word=1.
REQ-033 word_ready_i=0 held while 64 symbols arrive -> first word kept, second lost, overflow_o=1 until rst_i.
REQ-034 WORDS_PER_FRAME=4, stream 5 words -> addresses 0,1,2,3,0; frame_done_o pulse after addr 3 (macro defined).
REQ-035 frame_start_i after 10 symbols of word 2 -> partial discarded, next completed word at addr 0 from symbols after strobe.
REQ-036 rst_i asserted while word_we_o high -> next cycle word_we_o=0, outputs zero, next word at addr 0.
